// File: rtl/path_delay_sampler.sv
// path_delay_sampler: launch/capture controller for a combinational delay path.
// Each trial holds pathInput steady for SETTLE_CYCLES cycles and then toggles it
// on the launch edge. It captures pathResult captureDelay+1 cycles later and
// compares the capture with the expected settled value. A batch of trials
// produces saturating pass/fail counts.
//
// Ports:
//   clk          - single clock
//   rst          - synchronous active-high reset
//   start        - begin a batch when idle (ignored while busy)
//   numTrials    - trials per batch, latched on an accepted start
//   captureDelay - capture is taken captureDelay+1 cycles after launch
//   pathInput    - registered drive into the delay path
//   pathResult   - delay path output, sampled directly by the capture flop
//   busy         - high while a batch is running (SETTLE/WAIT/EVAL)
//   done         - one-cycle pulse at batch end
//   passCount    - captures that matched the expected value in the last batch
//   failCount    - captures that did not match in the last batch
module path_delay_sampler #(
  parameter int unsigned TRIAL_W       = 16,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          INVERTING     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TRIAL_W-1:0] numTrials,
  input  logic [3:0]         captureDelay,
  (* keep = "true" *)
  output logic               pathInput,
  input  logic               pathResult,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   passCount,
  output logic [CNT_W-1:0]   failCount
);

  // The timer must hold both SETTLE_CYCLES-1 and the largest captureDelay (15).
  localparam int unsigned TMR_W = (SETTLE_CYCLES > 16) ? $clog2(SETTLE_CYCLES) : 4;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  state_t             state;
  logic [TRIAL_W-1:0] ntrials_q;
  logic [TRIAL_W-1:0] trial_idx;
  logic [TRIAL_W-1:0] trial_next;
  logic [3:0]         delay_q;
  logic [TMR_W-1:0]   tmr;

  // The capture may go metastable by design; it is only consumed in EVAL.
  (* keep = "true" *)
  logic               capture;

  assign trial_next = trial_idx + TRIAL_W'(1);

  // Batch controller with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pathInput <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      passCount <= '0;
      failCount <= '0;
      ntrials_q <= '0;
      trial_idx <= '0;
      delay_q   <= '0;
      tmr       <= '0;
      capture   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            passCount <= '0;
            failCount <= '0;
            if (numTrials != '0) begin
              ntrials_q <= numTrials;
              delay_q   <= captureDelay;
              trial_idx <= '0;
              tmr       <= '0;
              busy      <= 1'b1;
              state     <= S_SETTLE;
            end else begin
              // Empty batch: just report completion with cleared counts.
              done <= 1'b1;
            end
          end
        end

        S_SETTLE: begin
          if (tmr == SETTLE_LAST) begin
            // Launch edge: direction alternates every trial.
            tmr       <= '0;
            pathInput <= ~pathInput;
            state     <= S_WAIT;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_WAIT: begin
          if (tmr == TMR_W'(delay_q)) begin
            tmr     <= '0;
            capture <= pathResult;
            state   <= S_EVAL;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end

        S_EVAL: begin
          if (capture == (pathInput ^ INVERTING)) begin
            if (passCount != CNT_MAX) passCount <= passCount + CNT_W'(1);
          end else begin
            if (failCount != CNT_MAX) failCount <= failCount + CNT_W'(1);
          end
          trial_idx <= trial_next;
          if (trial_next == ntrials_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_sampler.sv
// Self-checking bench for path_delay_sampler: directed batches with expected
// results queued at issue time and checked by per-instance done monitors.
module tb_path_delay_sampler;

  localparam int unsigned SETTLE = 4;

  typedef struct {
    int   pass;
    int   fail;
    logic pin;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [15:0] num_trials;
  logic [3:0]  capture_delay;
  logic        pin_a, pin_b;
  logic        res_a, res_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic [15:0] pass_a, fail_a;
  logic [2:0]  pass_b, fail_b;

  int   mode;
  logic d1, d2, d3;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  path_delay_sampler #(
    .TRIAL_W(16), .CNT_W(16), .SETTLE_CYCLES(SETTLE), .INVERTING(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .numTrials(num_trials),
    .captureDelay(capture_delay), .pathInput(pin_a), .pathResult(res_a),
    .busy(busy_a), .done(done_a), .passCount(pass_a), .failCount(fail_a)
  );

  path_delay_sampler #(
    .TRIAL_W(16), .CNT_W(3), .SETTLE_CYCLES(SETTLE), .INVERTING(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .numTrials(num_trials),
    .captureDelay(capture_delay), .pathInput(pin_b), .pathResult(res_b),
    .busy(busy_b), .done(done_b), .passCount(pass_b), .failCount(fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Three-flop inverting delay line model of a slow path.
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b1; d2 <= 1'b1; d3 <= 1'b1;
    end else begin
      d1 <= ~pin_a; d2 <= d1; d3 <= d2;
    end
  end

  always_comb begin
    case (mode)
      0:       res_a = ~pin_a;
      1:       res_a = pin_a;
      default: res_a = d3;
    endcase
  end

  assign res_b = ~pin_b;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop the expected result whenever a batch completes.
  always @(negedge clk) begin
    exp_t ea;
    if (done_a) begin
      if (q_a.size() == 0) begin
        check("unexpected_done_a", 1, 0);
      end else begin
        ea = q_a.pop_front();
        check("pass_a", int'(pass_a), ea.pass);
        check("fail_a", int'(fail_a), ea.fail);
        check("pin_a",  int'(pin_a),  int'(ea.pin));
      end
    end
  end

  always @(negedge clk) begin
    exp_t eb;
    if (done_b) begin
      if (q_b.size() == 0) begin
        check("unexpected_done_b", 1, 0);
      end else begin
        eb = q_b.pop_front();
        check("pass_b", int'(pass_b), eb.pass);
        check("fail_b", int'(fail_b), eb.fail);
        check("pin_b",  int'(pin_b),  int'(eb.pin));
      end
    end
  end

  // Issue one batch, optionally poke start mid-batch, and check timing.
  task automatic run_batch(input bit sel, input int n, input int d,
                           input int ep, input int ef, input logic epin,
                           input int poke);
    exp_t e;
    int   cyc;
    int   bcnt;
    e.pass = ep; e.fail = ef; e.pin = epin;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
    @(negedge clk);
    num_trials    = 16'(n);
    capture_delay = 4'(d);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!(sel ? done_b : done_a) && cyc < 400) begin
      if (sel ? busy_b : busy_a) bcnt++;
      if (!sel && cyc == poke) begin
        start_a       = 1'b1;
        num_trials    = 16'd3;
        capture_delay = 4'd5;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    check(sel ? "latency_b" : "latency_a", cyc, n * (SETTLE + d + 2));
    check(sel ? "busy_cycles_b" : "busy_cycles_a", bcnt, n * (SETTLE + d + 2));
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    num_trials = '0; capture_delay = '0; mode = 0;
    repeat (3) @(negedge clk);
    check("rst_pin",  int'(pin_a),  0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_pass", int'(pass_a), 0);
    check("rst_fail", int'(fail_a), 0);
    rst = 1'b0;

    // Zero-delay inverting path: all pass, even toggles return pin to 0.
    mode = 0; run_batch(1'b0, 10, 0, 10, 0, 1'b0, -1);
    // Non-inverting path against INVERTING=1: all fail.
    mode = 1; run_batch(1'b0, 7, 0, 0, 7, 1'b1, -1);
    // Three-cycle path: capture too early, then just in time.
    mode = 2; run_batch(1'b0, 8, 2, 0, 8, 1'b1, -1);
    mode = 2; run_batch(1'b0, 8, 3, 8, 0, 1'b1, -1);
    // Empty batch: immediate done, counters cleared.
    mode = 0; run_batch(1'b0, 0, 0, 0, 0, 1'b1, -1);
    // Start poked mid-batch with other settings is ignored.
    mode = 0; run_batch(1'b0, 5, 1, 5, 0, 1'b0, 10);

    // Reset during WAIT aborts the batch with no done pulse.
    @(negedge clk);
    num_trials = 16'd4; capture_delay = 4'd3; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", int'(busy_a), 1);
    check("pre_rst_pin",  int'(pin_a),  1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pin",  int'(pin_a),  0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    check("abort_pass", int'(pass_a), 0);
    check("abort_fail", int'(fail_a), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", int'(busy_a), 0);

    // Narrow counters saturate.
    run_batch(1'b1, 12, 0, 7, 0, 1'b0, -1);

    repeat (2) @(negedge clk);
    check("sb_empty_a", q_a.size(), 0);
    check("sb_empty_b", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/path_delay_sampler.md
Name: path_delay_sampler

Overview:
- Launch/capture controller that drives the input of a combinational delay path (inverter chain) and samples its output a programmable number of clock periods later.
- Runs a batch of trials and counts how many captures matched the expected settled value (pass) and how many did not (fail).
- Provides coarse, cycle-granular timing characterisation of the path as the measuring end of the delay-sensor chain.

Parameters:
- TRIAL_W, 16, width of the trial-count request.
- CNT_W, 16, width of the pass/fail counters; counters saturate.
- SETTLE_CYCLES, 4, cycles pathInput is held stable before each launch edge (≥1).
- INVERTING, 1, 1 when the path has an odd inversion count; expected capture = pathInput ^ INVERTING.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a batch when idle; ignored while busy.
- numTrials  in  TRIAL_W  trials per batch; latched on accepted start.
- captureDelay  in  4  capture occurs captureDelay+1 clk periods after launch edge; latched on accepted start.
- pathInput  out  1  registered drive into the delay path.
- pathResult  in  1  delay path output; sampled directly by capture flop, no synchroniser.
- busy  out  1  high from accepted start until DONE state.
- done  out  1  one-cycle pulse at batch end.
- passCount  out  CNT_W  matching captures in last batch.
- failCount  out  CNT_W  mismatching captures in last batch.

Behaviour:
- Reset: state IDLE; pathInput=0, busy=0, done=0, passCount=0, failCount=0; internal counters and latches cleared. Reset mid-batch aborts immediately; no done pulse.
- IDLE
  - start=1 and numTrials!=0: latch numTrials and captureDelay, clear pass/fail, trial index=0 → SETTLE; busy=1 from next cycle.
  - start=1 and numTrials==0: clear pass/fail, done pulses next cycle, stay IDLE.
- SETTLE
  - Lasts exactly SETTLE_CYCLES cycles; pathInput constant.
  - On the exit edge pathInput toggles (launch edge) → WAIT.
- WAIT
  - Lasts captureDelay+1 cycles.
  - On the exit edge the capture flop registers pathResult → EVAL.
- EVAL (1 cycle)
  - Compare capture with pathInput ^ INVERTING; equal → passCount+1, else failCount+1.
  - Both counters saturate at 2^CNT_W−1.
  - Trial index+1; if equal to latched numTrials → DONE, else → SETTLE.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- busy timing: busy=1 in SETTLE, WAIT and EVAL.
- Trial period = SETTLE_CYCLES + captureDelay + 2 cycles. done is high in cycle N·(SETTLE_CYCLES+captureDelay+2)+1 counting the start-accept edge as cycle 0.
- pathInput alternates direction every trial, so rising and falling transitions are measured equally. pathInput is not reset between batches.
- start while busy: ignored, no effect on latched values.
- start held high through DONE: re-accepted on the IDLE cycle after DONE.
- passCount/failCount hold their values after done until the next accepted start.
- passCount+failCount always equals trials completed (below saturation).
- Capture flop and pathInput flop carry keep attributes; the capture may be metastable by design and is used only in EVAL.

Test Plan:
- Bench ties pathResult=~pathInput (zero delay), INVERTING=1, numTrials=10, captureDelay=0 → done after 10·6+1 cycles; passCount=10, failCount=0; pathInput ends at reset value (even toggles).
- Bench ties pathResult=pathInput, INVERTING=1, numTrials=7 → passCount=0, failCount=7; busy high exactly 7·6 cycles.
- pathResult = ~pathInput through a 3-flop delay line, numTrials=8:
  - captureDelay=2 → fail=8.
  - captureDelay=3 → pass=8.
- start with numTrials=0 → done pulses next cycle, busy stays 0, counters cleared from previous batch.
- start pulsed again mid-batch with different numTrials/captureDelay → ignored; results match the original request.
- rst asserted mid-WAIT → next cycle all outputs 0, state IDLE, no done. Then CNT_W=3 build with numTrials=12 all-pass → passCount saturates at 7, failCount=0.
